eth_mac_tx_framer: RTL and testbench

Downstream neighbour of ip_packet_tx. Consumes its byte-wide valid/ready/last/tuser frame stream (DA..payload, no FCS) and drives a GMII-style transmit interface. Prepends preamble and SFD, optionally pads short frames, appends the IEEE 802.3 CRC32 FCS, and enforces the inter-frame gap.

---
 rtl/eth_mac_tx_framer.sv | 190 +++++++++++++++++++
 tb/tb_eth_mac_tx_framer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_tx_framer.sv
// eth_mac_tx_framer: byte-stream to GMII transmit framer.
// Adds preamble/SFD, appends the IEEE 802.3 CRC32 FCS and enforces the
// inter-frame gap. Short-frame zero padding is built only when the macro
// ETH_TX_PAD_EN is defined.
module eth_mac_tx_framer #(
    parameter int PREAMBLE_BYTES  = 7,
`ifdef ETH_TX_PAD_EN
    parameter int MIN_FRAME_BYTES = 60,
`endif
    parameter int IFG_CYCLES      = 12
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic [7:0] S_DATA,
    input  logic       S_VALID,
    output logic       S_READY,
    input  logic       S_LAST,
    input  logic       S_TUSER,
    output logic [7:0] TXD,
    output logic       TX_EN,
    output logic       TX_ER,
    output logic       TX_BUSY,
    output logic       FRAME_DONE
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_ABORT,
`ifdef ETH_TX_PAD_EN
        ST_PAD,
`endif
        ST_FCS,
        ST_IFG
    } state_t;

    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
`ifdef ETH_TX_PAD_EN
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_BYTES);
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        done_q, done_d;

    logic [10:0] byte_cnt_inc;
    logic [31:0] fcs;

    // Reflected CRC32 (poly 0xEDB88320), one byte per call.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign fcs          = ~crc_q;

    assign S_READY    = (state_q == ST_DATA);
    assign TX_BUSY    = (state_q != ST_IDLE);
    assign TXD        = txd_q;
    assign TX_EN      = tx_en_q;
    assign TX_ER      = tx_er_q;
    assign FRAME_DONE = done_q;

    // State and registered GMII outputs; reset kills a frame in progress at once.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            crc_q      <= 32'hFFFFFFFF;
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output decode; the line is idle unless a state drives it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        txd_d      = 8'h00;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Start the preamble; the pending byte is taken later in DATA.
                if (S_VALID) begin
                    txd_d   = 8'h55;
                    tx_en_d = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                if (cnt_q < PRE_LAST) begin
                    txd_d = 8'h55;
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    txd_d      = 8'hD5;
                    crc_d      = 32'hFFFFFFFF;
                    byte_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_en_d = 1'b1;
                if (S_VALID) begin
                    txd_d      = S_DATA;
                    tx_er_d    = S_TUSER;
                    crc_d      = crc_byte(crc_q, S_DATA);
                    byte_cnt_d = byte_cnt_inc;
                    if (S_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_FCS;
`ifdef ETH_TX_PAD_EN
                        if (byte_cnt_inc < MIN_LEN)
                            state_d = ST_PAD;
`endif
                    end
                end else begin
                    // GMII cannot stall: flag the frame as corrupt and give up.
                    txd_d   = 8'h00;
                    tx_er_d = 1'b1;
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                cnt_d   = '0;
                state_d = ST_IFG;
            end
`ifdef ETH_TX_PAD_EN
            ST_PAD: begin
                tx_en_d    = 1'b1;
                crc_d      = crc_byte(crc_q, 8'h00);
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= MIN_LEN) begin
                    cnt_d   = '0;
                    state_d = ST_FCS;
                end
            end
`endif
            ST_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q[1:0] == 2'd3) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IFG;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_IFG: begin
                if (cnt_q >= IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// Scoreboard bench for eth_mac_tx_framer: every expected GMII byte is queued
// when a frame is driven and popped as TX_EN cycles appear.
module tb_eth_mac_tx_framer;

    localparam int PRE = 7;
    localparam int IFG = 12;
    localparam int MINF = 60;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [7:0] S_DATA;
    logic       S_VALID, S_LAST, S_TUSER;
    logic       S_READY;
    logic [7:0] TXD;
    logic       TX_EN, TX_ER, TX_BUSY, FRAME_DONE;

    eth_mac_tx_framer dut (
        .ACLK(ACLK), .ARESET(ARESET), .S_DATA(S_DATA), .S_VALID(S_VALID),
        .S_READY(S_READY), .S_LAST(S_LAST), .S_TUSER(S_TUSER), .TXD(TXD),
        .TX_EN(TX_EN), .TX_ER(TX_ER), .TX_BUSY(TX_BUSY), .FRAME_DONE(FRAME_DONE)
    );

    always #5 ACLK = ~ACLK;

    int nchk = 0;
    int nerr = 0;
    logic [9:0] exp_q[$];   // {TXD, TX_ER, FRAME_DONE}
    int         len_q[$];   // expected TX_EN burst lengths
    logic [7:0] pay[256];
    bit         sb_en = 1'b1;
    int         run = 0;
    int         gap = 0;
    bit         gap_on = 1'b0;
    logic [31:0] last4 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit-serial reference CRC32 (reflected).
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
        logic fb;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Monitor: compare every TX_EN cycle, burst lengths and the post-frame gap.
    always @(negedge ACLK) begin
        if (ARESET || !sb_en) begin
            run    = 0;
            gap_on = 1'b0;
        end else begin
            if (TX_EN) begin
                run++;
                last4 = {TXD, last4[31:8]};
                if (exp_q.size() == 0) chk("tx_unexpected", 0, 1);
                else chk("tx_byte", {TXD, TX_ER, FRAME_DONE}, exp_q.pop_front());
            end else if (run > 0) begin
                if (len_q.size() == 0) chk("tx_len_unexpected", 0, 1);
                else chk("tx_en_len", run, len_q.pop_front());
                run = 0;
            end
            if (gap_on) begin
                gap++;
                chk("ifg_txen", TX_EN, 0);
                if (!TX_BUSY) begin
                    chk("ifg_len", gap, IFG);
                    gap_on = 1'b0;
                end
            end
            if (FRAME_DONE) begin
                gap_on = 1'b1;
                gap    = 0;
            end
        end
    end

    task automatic wait_hs();
        logic r;
        for (int t = 0; t < 500; t++) begin
            @(negedge ACLK);
            r = S_READY;
            @(posedge ACLK);
            if (r) return;
        end
        chk("hs_timeout", 0, 1);
    endtask

    // kind 0: normal, 1: underrun after stop bytes, 2: reset after stop bytes
    task automatic send_frame(input int n, input int kind, input int stop, input int err_idx);
        logic [31:0] crc;
        int nb, total;
        nb = (kind == 0) ? n : stop;
        if (kind != 2) begin
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < PRE; i++) exp_q.push_back({8'h55, 2'b00});
            exp_q.push_back({8'hD5, 2'b00});
            for (int i = 0; i < nb; i++) begin
                exp_q.push_back({pay[i], (i == err_idx), 1'b0});
                crc = ref_crc(crc, pay[i]);
            end
            if (kind == 1) begin
                exp_q.push_back({8'h00, 2'b10});
                len_q.push_back(PRE + 1 + nb + 1);
            end else begin
                total = n;
`ifdef ETH_TX_PAD_EN
                while (total < MINF) begin
                    exp_q.push_back(10'h000);
                    crc = ref_crc(crc, 8'h00);
                    total++;
                end
`endif
                crc = ~crc;
                for (int k = 0; k < 4; k++) exp_q.push_back({crc[8*k +: 8], 1'b0, (k == 3)});
                len_q.push_back(PRE + 1 + total + 4);
            end
        end
        for (int i = 0; i < nb; i++) begin
            S_VALID = 1'b1;
            S_DATA  = pay[i];
            S_LAST  = (kind == 0) && (i == n - 1);
            S_TUSER = (i == err_idx);
            wait_hs();
            #1;
        end
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        S_TUSER = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || len_q.size() > 0 || TX_BUSY) && t < 400) begin
            @(negedge ACLK);
            t++;
        end
        chk("drain_timeout", (t < 400), 1);
        @(negedge ACLK);
        @(negedge ACLK);
    endtask

    initial begin
        S_DATA = 8'h00; S_VALID = 1'b0; S_LAST = 1'b0; S_TUSER = 1'b0;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #2;
        chk("rst_txd", TXD, 8'h00);
        chk("rst_tx_en", TX_EN, 0);
        chk("rst_tx_er", TX_ER, 0);
        chk("rst_s_ready", S_READY, 0);
        chk("rst_busy", TX_BUSY, 0);
        chk("rst_done", FRAME_DONE, 0);
        @(negedge ACLK) ARESET = 1'b0;
        repeat (5) @(posedge ACLK);
        #1;
        chk("idle_tx_en", TX_EN, 0);
        chk("idle_busy", TX_BUSY, 0);

        // "123456789": known FCS 0xCBF43926, LSB first on the wire.
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        send_frame(9, 0, 0, -1);
        drain();
`ifndef ETH_TX_PAD_EN
        chk("fcs_123456789", last4, 32'hCBF43926);
`endif

        // Minimum-size frame with random payload.
        for (int i = 0; i < 60; i++) pay[i] = 8'($urandom_range(0, 255));
        send_frame(60, 0, 0, -1);
        drain();

        // Short frame: padded to 60 only when padding is built in.
        for (int i = 0; i < 42; i++) pay[i] = 8'($urandom_range(0, 255));
        send_frame(42, 0, 0, -1);
        drain();

        // Underrun after 20 payload bytes.
        for (int i = 0; i < 40; i++) pay[i] = 8'(i * 3 + 1);
        send_frame(40, 1, 20, -1);
        drain();
        chk("underrun_busy", TX_BUSY, 0);

        // Upstream error flag on payload byte 5 only.
        for (int i = 0; i < 30; i++) pay[i] = 8'($urandom_range(0, 255));
        send_frame(30, 0, 0, 5);
        drain();

        // Asynchronous reset during payload byte 30.
        sb_en = 1'b0;
        for (int i = 0; i < 50; i++) pay[i] = 8'(i + 8'h80);
        send_frame(50, 2, 30, -1);
        #2 ARESET = 1'b1;
        #1;
        chk("arst_tx_en", TX_EN, 0);
        chk("arst_s_ready", S_READY, 0);
        chk("arst_busy", TX_BUSY, 0);
        @(posedge ACLK);
        @(negedge ACLK) ARESET = 1'b0;
        exp_q.delete();
        len_q.delete();
        sb_en = 1'b1;

        // Fresh frame after reset.
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        send_frame(9, 0, 0, -1);
        drain();

        // Back-to-back frames: S_VALID held through the gap.
        for (int i = 0; i < 10; i++) pay[i] = 8'(8'hA0 + i);
        send_frame(10, 0, 0, -1);
        S_VALID = 1'b1;
        S_DATA  = pay[0];
        send_frame(10, 0, 0, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
